// File: rtl/bist_pkg.sv
// Shared definitions for the BIST memory-test engine.
//   DIR_UP / DIR_DOWN : encodings of the up_down direction input
//   BIST_ADR_SIZE     : default address width
//   addr_max()        : all-ones address for a given width (valid for width < 64)
package bist_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned BIST_ADR_SIZE = 8;

   function automatic logic [63:0] addr_max(input int unsigned width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/bist_addr_tc.sv
// Terminal-count comparator for the BIST address counter.
// Raises c_out for the cycle whose next enabled edge would wrap (or park, in
// saturating builds) the address in the current direction.
// Ports:
//   adress  in  Width  current counter value
//   up_down in  1      direction (DIR_UP increments, DIR_DOWN decrements)
//   enable  in  1      count enable; c_out is forced low while deasserted
//   c_out   out 1      terminal-count flag (purely combinational)
module bist_addr_tc
   import bist_pkg::*;
#(
   parameter int unsigned Width = BIST_ADR_SIZE
) (
   input  logic [Width-1:0] adress,
   input  logic             up_down,
   input  logic             enable,
   output logic             c_out
);

   localparam logic [Width-1:0] Max = Width'(addr_max(Width));

   logic at_max;
   logic at_min;

   always_comb begin
      at_max = (adress == Max);
      at_min = (adress == '0);
      c_out  = enable & (((up_down == DIR_UP) & at_max) | ((up_down == DIR_DOWN) & at_min));
   end

endmodule

// File: rtl/bist_addr_gen.sv
// Up/down binary address counter for the BIST memory-test engine.
// Walks the address space ascending or descending under march-test control and
// flags the terminal address of the sweep on c_out.
// Build option: define BIST_ADDR_GEN_SAT_EN to saturate at MAX/0 instead of
// wrapping; c_out behaves identically in both builds.
// Ports:
//   clk        in  1         rising-edge clock
//   rst_adr    in  1         asynchronous active-high reset, clears the counter
//   pr_res_adr in  1         synchronous preset to MAX, overrides enable
//   enable     in  1         count enable, counter holds when low
//   up_down    in  1         1 = increment, 0 = decrement
//   adress     out Adr_size  registered current address
//   c_out      out 1         terminal-count flag (combinational)
module bist_addr_gen
   import bist_pkg::*;
#(
   parameter int unsigned Adr_size = BIST_ADR_SIZE
) (
   input  logic                clk,
   input  logic                rst_adr,
   input  logic                pr_res_adr,
   input  logic                enable,
   input  logic                up_down,
   output logic [Adr_size-1:0] adress,
   output logic                c_out
);

   localparam logic [Adr_size-1:0] Max = Adr_size'(addr_max(Adr_size));

   logic [Adr_size-1:0] adress_q;
   logic [Adr_size-1:0] adress_d;

   always_comb begin
      adress_d = adress_q;
      if (pr_res_adr) begin
         adress_d = Max;
      end else if (enable) begin
         if (up_down == DIR_UP) begin
`ifdef BIST_ADDR_GEN_SAT_EN
            if (adress_q != Max) adress_d = adress_q + 1'b1;
`else
            adress_d = adress_q + 1'b1;
`endif
         end else begin
`ifdef BIST_ADDR_GEN_SAT_EN
            if (adress_q != '0) adress_d = adress_q - 1'b1;
`else
            adress_d = adress_q - 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst_adr) begin
      if (rst_adr) begin
         adress_q <= '0;
      end else begin
         adress_q <= adress_d;
      end
   end

   assign adress = adress_q;

   bist_addr_tc #(
      .Width (Adr_size)
   ) u_tc (
      .adress  (adress_q),
      .up_down (up_down),
      .enable  (enable),
      .c_out   (c_out)
   );

endmodule

// File: tb/tb_bist_addr_gen.sv
// Directed self-checking bench for bist_addr_gen (8-bit address).
module tb_bist_addr_gen;

`ifdef BIST_ADDR_GEN_SAT_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   logic       clk;
   logic       rst_adr;
   logic       pr_res_adr;
   logic       enable;
   logic       up_down;
   logic [7:0] adress;
   logic       c_out;

   int checks;
   int fails;

   bist_addr_gen #(
      .Adr_size (8)
   ) dut (
      .clk        (clk),
      .rst_adr    (rst_adr),
      .pr_res_adr (pr_res_adr),
      .enable     (enable),
      .up_down    (up_down),
      .adress     (adress),
      .c_out      (c_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Short asynchronous reset pulse placed between edges.
   task automatic pulse_reset();
      #1 rst_adr = 1'b1;
      #1 rst_adr = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_adr    = 1'b1;
      pr_res_adr = 1'b0;
      enable     = 1'b0;
      up_down    = 1'b1;
      repeat (10) tick();
      checks++;
      if (adress !== 8'h00) begin
         fails++;
         $display("FAIL reset_adress: got %h expected 00", adress);
      end
      checks++;
      if (c_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_c_out: got %b expected 0", c_out);
      end
      rst_adr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (adress !== 8'h00) begin
            fails++;
            $display("FAIL idle_after_reset[%0d]: got %h expected 00", i, adress);
         end
      end
   endtask

   task automatic test_count_up();
      logic [7:0] exp;
      enable  = 1'b1;
      up_down = 1'b1;
      for (int i = 1; i < 256; i++) begin
         tick();
         exp = 8'(i);
         checks++;
         if (adress !== exp) begin
            fails++;
            $display("FAIL count_up_adress: got %h expected %h", adress, exp);
         end
         checks++;
         if (c_out !== (i == 255)) begin
            fails++;
            $display("FAIL count_up_c_out at %h: got %b expected %b", exp, c_out, (i == 255));
         end
      end
      tick();
      exp = Sat ? 8'hFF : 8'h00;
      checks++;
      if (adress !== exp) begin
         fails++;
         $display("FAIL count_up_wrap: got %h expected %h", adress, exp);
      end
      checks++;
      if (c_out !== Sat) begin
         fails++;
         $display("FAIL count_up_wrap_c_out: got %b expected %b", c_out, Sat);
      end
   endtask

   task automatic test_preset_down();
      logic [7:0] exp;
      pulse_reset();
      enable  = 1'b1;
      up_down = 1'b1;
      repeat (5) tick();
      checks++;
      if (adress !== 8'h05) begin
         fails++;
         $display("FAIL pre_preset_count: got %h expected 05", adress);
      end
      pr_res_adr = 1'b1;
      tick();
      pr_res_adr = 1'b0;
      checks++;
      if (adress !== 8'hFF) begin
         fails++;
         $display("FAIL preset_adress: got %h expected ff", adress);
      end
      checks++;
      if (c_out !== 1'b1) begin
         fails++;
         $display("FAIL preset_c_out_up: got %b expected 1", c_out);
      end
      up_down = 1'b0;
      #1;
      checks++;
      if (c_out !== 1'b0) begin
         fails++;
         $display("FAIL preset_c_out_down: got %b expected 0", c_out);
      end
      for (int i = 254; i >= 0; i--) begin
         tick();
         exp = 8'(i);
         checks++;
         if (adress !== exp) begin
            fails++;
            $display("FAIL count_down_adress: got %h expected %h", adress, exp);
         end
         checks++;
         if (c_out !== (i == 0)) begin
            fails++;
            $display("FAIL count_down_c_out at %h: got %b expected %b", exp, c_out, (i == 0));
         end
      end
      tick();
      exp = Sat ? 8'h00 : 8'hFF;
      checks++;
      if (adress !== exp) begin
         fails++;
         $display("FAIL count_down_wrap: got %h expected %h", adress, exp);
      end
   endtask

   task automatic test_hold();
      pulse_reset();
      enable  = 1'b1;
      up_down = 1'b1;
      repeat (8'h42) tick();
      checks++;
      if (adress !== 8'h42) begin
         fails++;
         $display("FAIL hold_setup: got %h expected 42", adress);
      end
      enable = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++;
         if (adress !== 8'h42 || c_out !== 1'b0) begin
            fails++;
            $display("FAIL hold[%0d]: got adress=%h c_out=%b expected 42/0", i, adress, c_out);
         end
      end
   endtask

   task automatic test_async_reset();
      pulse_reset();
      enable  = 1'b1;
      up_down = 1'b1;
      repeat (8'h80) tick();
      checks++;
      if (adress !== 8'h80) begin
         fails++;
         $display("FAIL async_setup: got %h expected 80", adress);
      end
      #2;
      rst_adr    = 1'b1;
      pr_res_adr = 1'b1;
      #1;
      checks++;
      if (adress !== 8'h00) begin
         fails++;
         $display("FAIL async_reset_between_edges: got %h expected 00", adress);
      end
      repeat (2) tick();
      checks++;
      if (adress !== 8'h00) begin
         fails++;
         $display("FAIL reset_over_preset: got %h expected 00", adress);
      end
      rst_adr    = 1'b0;
      pr_res_adr = 1'b0;
      enable     = 1'b0;
      tick();
      checks++;
      if (adress !== 8'h00) begin
         fails++;
         $display("FAIL post_reset_idle: got %h expected 00", adress);
      end
      enable = 1'b1;
      tick();
      checks++;
      if (adress !== 8'h01) begin
         fails++;
         $display("FAIL resume_from_zero: got %h expected 01", adress);
      end
   endtask

   task automatic test_dir_toggle();
      logic [7:0] exp;
      pulse_reset();
      enable  = 1'b1;
      up_down = 1'b1;
      #1;
      checks++;
      if (c_out !== 1'b0) begin
         fails++;
         $display("FAIL toggle_c_out_up_at_0: got %b expected 0", c_out);
      end
      up_down = 1'b0;
      #1;
      checks++;
      if (c_out !== 1'b1) begin
         fails++;
         $display("FAIL toggle_c_out_down_at_0: got %b expected 1", c_out);
      end
      tick();
      exp = Sat ? 8'h00 : 8'hFF;
      checks++;
      if (adress !== exp) begin
         fails++;
         $display("FAIL toggle_next_adress: got %h expected %h", adress, exp);
      end
      enable = 1'b0;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_count_up();
      test_preset_down();
      test_hold();
      test_async_reset();
      test_dir_toggle();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
